vec_alu_pipe: RTL and testbench
===============================

// Module: vec_alu_pipe
// PURPOSE
// - Parametrised vector execute stage: LANES independent LANE_W-bit lanes, STAGES-deep registered pipeline.
// - Valid/ready handshake with backpressure on both sides; synchronous flush for branch redirect.
// - Sits between the ID/EX register and the EX/MEM register, alongside the scalar ALU.
// - Per-lane mask, scalar broadcast and optional unsigned saturation.
// PARAMETERS
// - LANES   6  lane count; data width W = LANES*LANE_W (default 48)
// - LANE_W  8  bits per lane
// - STAGES  2  pipeline depth, >=1; latency in cycles with no stall
// - SAT     1  1: ADD/SUB saturate unsigned per lane; 0: wrap modulo 2^LANE_W
// PORTS
// - clk        in   1       clock, rising edge
// - rst        in   1       reset, asynchronous, active-low
// - flush      in   1       synchronous; kill all in-flight ops
// - in_valid   in   1       input op valid
// - in_ready   out  1       stage can accept input this cycle
// - op         in   4       operation code, see BEHAVIOUR
// - src_a      in   W       vector operand A
// - src_b      in   W       vector operand B
// - scalar     in   32      broadcast source; low LANE_W bits used
// - bcast      in   1       1: every B lane = scalar[LANE_W-1:0]
// - lane_mask  in   LANES   0 in bit i: lane i result = A lane i
// - vd_in      in   5       destination vector register tag
// - out_valid  out  1       result valid
// - out_ready  in   1       downstream accepts result
// - result     out  W       vector result
// - vd_out     out  5       tag carried with result
// - illegal    out  1       op was undefined (result is zero)
// BEHAVIOUR
// - Reset (rst=0, async): all stage valid bits, out_valid, result, vd_out, illegal = 0. in_ready = 1 once rst=1.
// - Ops: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 MINU, 8 MAXU, 9 PASSB.
// - Ops 10-15: result 0, illegal=1, tag still carried.
// - Shifts: amount = B lane mod LANE_W; zero fill; no cross-lane carry.
// - Lane math is unsigned, per lane, no carry between lanes.
// - SAT=1: ADD clamps to 2^LANE_W-1; SUB clamps to 0.
// - Mask applies after the op; masked lanes are never saturated.
// - Compute happens in stage 0; stages 1..STAGES-1 hold registers only.
// - Stage k advances when it is empty or stage k+1 advances.
// - The last stage advances when out_ready=1.
// - in_ready = ~valid[0] | adv[0], combinational. No bubble at full throughput: 1 op/cycle.
// - Transfer in: in_valid & in_ready. Transfer out: out_valid & out_ready.
// - Stalled stages hold data, tag and illegal unchanged.
// - Latency: STAGES cycles from input transfer to out_valid, with out_ready held high.
// - Capacity: STAGES ops.
// - Full: in_ready=0 only when all stages are valid and out_ready=0.
// - flush=1 at an edge: all valid bits cleared, an input presented that cycle is dropped.
// - flush: out_valid=0 the next cycle. Data registers may keep stale values.
// - flush with out_ready=1 in the same cycle: the output-stage op counts as consumed by downstream this cycle.
// - Reset mid-operation: all in-flight ops are lost immediately; no partial output.
// - Outputs are registered. out_valid never drops without a transfer, except on flush or reset.
// TESTING
// - ADD, SAT=1: A=0xF0_10_00_7F_01_FF, B=0x20_10_00_01_01_01 -> 0xFF_20_00_80_02_FF, out_valid after 2 cycles.
// - SUB, SAT=0: A=0x00.., B=0x01 bcast (scalar=1) -> every lane 0xFF. Same op with SAT=1 -> every lane 0x00.
// - Mask: lane_mask=6'b000011, op=XOR, A=0x111111111111, B=0xFFFFFFFFFFFF -> 0x11111111EEEE.
// - Backpressure: 5 back-to-back ops, out_ready=0 for cycles 2-6.
// - Backpressure expected: in_ready falls after 2 accepted, no loss or duplication, tags out in order 1..5.
// - Flush with 2 ops in flight plus in_valid=1 -> out_valid=0 the next cycle, nothing emitted.
// - Flush, then next op: accepted the following cycle and emitted after 2 cycles.
// - op=12, vd_in=7 -> result 0, illegal=1, vd_out=7.
// - Assert rst=0 mid-stall: outputs 0 asynchronously, in_ready=1 after release.

Source files
------------

// File: rtl/vec_alu_pipe.sv
// vec_alu_pipe: lane-parallel vector execute stage with an elastic STAGES-deep output pipeline.
module vec_alu_pipe #(
   parameter int LANES  = 6,
   parameter int LANE_W = 8,
   parameter int STAGES = 2,
   parameter int SAT    = 1
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      flush,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [3:0]                op,
   input  logic [LANES*LANE_W-1:0]   src_a,
   input  logic [LANES*LANE_W-1:0]   src_b,
   input  logic [31:0]               scalar,
   input  logic                      bcast,
   input  logic [LANES-1:0]          lane_mask,
   input  logic [4:0]                vd_in,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [LANES*LANE_W-1:0]   result,
   output logic [4:0]                vd_out,
   output logic                      illegal
);
   localparam int W = LANES*LANE_W;
   localparam logic [LANE_W-1:0] LW = LANE_W'(LANE_W);
   logic [W-1:0] res_c;
   logic ill_c;
   logic [STAGES-1:0] v, adv;
   logic [W-1:0] d [STAGES];
   logic [4:0] t [STAGES];
   logic [STAGES-1:0] il;
   logic unused_scalar;
   assign unused_scalar = ^scalar[31:LANE_W];
   assign ill_c = op > 4'd9;
   for (genvar g = 0; g < LANES; g++) begin : lane
      logic [LANE_W-1:0] a, b, sh, r;
      logic [LANE_W:0] sum, dif;
      assign a = src_a[g*LANE_W +: LANE_W];
      assign b = bcast ? scalar[LANE_W-1:0] : src_b[g*LANE_W +: LANE_W];
      assign sh = b % LW;
      assign sum = {1'b0, a} + {1'b0, b};
      assign dif = {1'b0, a} - {1'b0, b};
      always_comb begin
         r = '0;
         case (op)
            4'd0: r = (SAT != 0 && sum[LANE_W]) ? '1 : sum[LANE_W-1:0];
            4'd1: r = (SAT != 0 && dif[LANE_W]) ? '0 : dif[LANE_W-1:0];
            4'd2: r = a & b;
            4'd3: r = a | b;
            4'd4: r = a ^ b;
            4'd5: r = a << sh;
            4'd6: r = a >> sh;
            4'd7: r = a < b ? a : b;
            4'd8: r = a > b ? a : b;
            4'd9: r = b;
            default: r = '0;
         endcase
      end
      // masked lanes pass A through untouched, so they never see saturation
      assign res_c[g*LANE_W +: LANE_W] = ill_c ? '0 : lane_mask[g] ? r : a;
   end
   // stage k may move when any stage from k to the output has a hole, or the output drains
   always_comb begin
      adv = '0;
      for (int k = 0; k < STAGES; k++) adv[k] = out_ready | ~&(v | STAGES'((1 << k) - 1));
   end
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         v <= '0;
         il <= '0;
         for (int k = 0; k < STAGES; k++) begin
            d[k] <= '0;
            t[k] <= '0;
         end
      end else begin
         for (int k = STAGES-1; k > 0; k--) begin
            if (adv[k]) begin
               v[k] <= v[k-1];
               d[k] <= d[k-1];
               t[k] <= t[k-1];
               il[k] <= il[k-1];
            end
         end
         if (adv[0]) begin
            v[0] <= in_valid;
            d[0] <= res_c;
            t[0] <= vd_in;
            il[0] <= ill_c;
         end
         if (flush) v <= '0;
      end
   end
   assign in_ready = adv[0];
   assign out_valid = v[STAGES-1];
   assign result = d[STAGES-1];
   assign vd_out = t[STAGES-1];
   assign illegal = il[STAGES-1];
endmodule

// File: tb/tb_vec_alu_pipe.sv
// tb_vec_alu_pipe: directed and random checks of vec_alu_pipe, saturating and wrapping builds side by side.
module tb_vec_alu_pipe;
   logic clk = 1'b0;
   logic rst, flush, in_valid, out_ready, bcast;
   logic [3:0] op;
   logic [47:0] src_a, src_b;
   logic [31:0] scalar;
   logic [5:0] lane_mask;
   logic [4:0] vd_in;
   logic s_in_ready, s_out_valid, s_illegal, w_in_ready, w_out_valid, w_illegal;
   logic [47:0] s_result, w_result;
   logic [4:0] s_vd_out, w_vd_out;
   int checks = 0, errors = 0, emitted = 0;
   logic acc, rdy;
   typedef struct {
      logic [47:0] r1;
      logic [47:0] r0;
      logic [4:0] tag;
      logic ill;
   } exp_t;
   exp_t q[$];

   always #5 clk = ~clk;

   vec_alu_pipe #(.LANES(6), .LANE_W(8), .STAGES(2), .SAT(1)) u_sat (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(s_in_ready),
      .op(op), .src_a(src_a), .src_b(src_b), .scalar(scalar), .bcast(bcast),
      .lane_mask(lane_mask), .vd_in(vd_in), .out_valid(s_out_valid), .out_ready(out_ready),
      .result(s_result), .vd_out(s_vd_out), .illegal(s_illegal));

   vec_alu_pipe #(.LANES(6), .LANE_W(8), .STAGES(2), .SAT(0)) u_wrap (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(w_in_ready),
      .op(op), .src_a(src_a), .src_b(src_b), .scalar(scalar), .bcast(bcast),
      .lane_mask(lane_mask), .vd_in(vd_in), .out_valid(w_out_valid), .out_ready(out_ready),
      .result(w_result), .vd_out(w_vd_out), .illegal(w_illegal));

   function automatic logic [47:0] model(input int o, input logic [47:0] a, input logic [47:0] b,
                                         input logic [31:0] sc, input logic bc, input logic [5:0] m,
                                         input int sat);
      logic [47:0] r = '0;
      if (o > 9) return '0;
      for (int i = 0; i < 6; i++) begin
         int x = int'(a[i*8 +: 8]);
         int y = bc ? int'(sc[7:0]) : int'(b[i*8 +: 8]);
         int z;
         case (o)
            0: z = sat != 0 ? (x + y > 255 ? 255 : x + y) : (x + y) % 256;
            1: z = sat != 0 ? (x < y ? 0 : x - y) : (x - y + 256) % 256;
            2: z = x & y;
            3: z = x | y;
            4: z = x ^ y;
            5: z = (x << (y % 8)) % 256;
            6: z = x >> (y % 8);
            7: z = x < y ? x : y;
            8: z = x > y ? x : y;
            default: z = y;
         endcase
         r[i*8 +: 8] = m[i] ? z[7:0] : x[7:0];
      end
      return r;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic vl, input logic [3:0] o, input logic [47:0] a, input logic [47:0] b,
                        input logic [31:0] sc, input logic bc, input logic [5:0] m, input logic [4:0] vd);
      in_valid = vl; op = o; src_a = a; src_b = b; scalar = sc; bcast = bc; lane_mask = m; vd_in = vd;
   endtask

   task automatic idle();
      drive(1'b0, 4'd0, '0, '0, '0, 1'b0, '0, '0);
   endtask

   // inputs are applied 1 time unit after an edge; sample mid-cycle, then advance one clock
   task automatic step();
      exp_t e;
      #1;
      rdy = s_in_ready;
      acc = in_valid && s_in_ready && !flush;
      chk("in_ready", 64'(s_in_ready), 64'(q.size() < 2 || out_ready));
      chk("in_ready_wrap", 64'(w_in_ready), 64'(q.size() < 2 || out_ready));
      if (s_out_valid && out_ready) begin
         chk("out_has_op", 64'(q.size() != 0), 64'(1));
         if (q.size() != 0) begin
            e = q.pop_front();
            emitted++;
            chk("result_sat", 64'(s_result), 64'(e.r1));
            chk("result_wrap", 64'(w_result), 64'(e.r0));
            chk("vd_out", 64'(s_vd_out), 64'(e.tag));
            chk("illegal", 64'(s_illegal), 64'(e.ill));
            chk("out_valid_wrap", 64'(w_out_valid), 64'(1));
         end
      end
      if (flush) q.delete();
      else if (acc) q.push_back('{model(int'(op), src_a, src_b, scalar, bcast, lane_mask, 1),
                                  model(int'(op), src_a, src_b, scalar, bcast, lane_mask, 0),
                                  vd_in, op > 4'd9});
      @(posedge clk);
      #1;
   endtask

   task automatic one(input logic [3:0] o, input logic [47:0] a, input logic [47:0] b, input logic [31:0] sc,
                      input logic bc, input logic [5:0] m, input logic [4:0] vd,
                      input logic [47:0] e1, input logic [47:0] e0);
      out_ready = 1'b1;
      flush = 1'b0;
      drive(1'b1, o, a, b, sc, bc, m, vd);
      step();
      chk("accepted", 64'(acc), 64'(1));
      idle();
      chk("lat1_valid", 64'(s_out_valid), 64'(0));
      step();
      chk("lat2_valid", 64'(s_out_valid), 64'(1));
      chk("dir_res_sat", 64'(s_result), 64'(e1));
      chk("dir_res_wrap", 64'(w_result), 64'(e0));
      chk("dir_vd", 64'(s_vd_out), 64'(vd));
      chk("dir_ill", 64'(s_illegal), 64'(o > 4'd9));
      step();
   endtask

   initial begin
      int acc_n, full_at, e_base;
      logic [4:0] tag;
      rst = 1'b1; flush = 1'b0; out_ready = 1'b1;
      idle();
      #2 rst = 1'b0;
      #1;
      chk("rst_out_valid", 64'(s_out_valid), 64'(0));
      chk("rst_result", 64'(s_result), 64'(0));
      chk("rst_vd_out", 64'(s_vd_out), 64'(0));
      chk("rst_illegal", 64'(s_illegal), 64'(0));
      chk("rst_wrap_valid", 64'(w_out_valid), 64'(0));
      @(posedge clk);
      #1 rst = 1'b1;
      #1 chk("rst_in_ready", 64'(s_in_ready), 64'(1));

      one(4'd0, 48'hF0_10_00_7F_01_FF, 48'h20_10_00_01_01_01, 32'd0, 1'b0, 6'h3F, 5'd1,
          48'hFF_20_00_80_02_FF, 48'h10_20_00_80_02_00);
      one(4'd1, 48'h0, 48'h123456789ABC, 32'h1, 1'b1, 6'h3F, 5'd2,
          48'h0, 48'hFF_FF_FF_FF_FF_FF);
      one(4'd4, 48'h111111111111, 48'hFFFFFFFFFFFF, 32'd0, 1'b0, 6'b000011, 5'd3,
          48'h11111111EEEE, 48'h11111111EEEE);
      one(4'd12, 48'hABCDEF012345, 48'h1, 32'd0, 1'b0, 6'h3F, 5'd7, 48'h0, 48'h0);

      // back-to-back ops with downstream stalled for cycles 2..6
      acc_n = 0; full_at = -1; e_base = emitted; tag = 5'd1;
      for (int c = 0; c < 20; c++) begin
         out_ready = !(c >= 2 && c <= 6);
         drive(tag <= 5'd5, 4'($urandom_range(0, 9)), 48'({$urandom(), $urandom()}),
               48'({$urandom(), $urandom()}), $urandom(), 1'b0, 6'h3F, tag);
         step();
         if (!rdy && full_at < 0) full_at = acc_n;
         if (acc) begin
            acc_n++;
            tag++;
         end
      end
      chk("bp_full_at", 64'(full_at), 64'(2));
      chk("bp_accepted", 64'(acc_n), 64'(5));
      chk("bp_emitted", 64'(emitted - e_base), 64'(5));

      // flush with two ops in flight and a third presented
      out_ready = 1'b1;
      drive(1'b1, 4'd0, 48'h1, 48'h1, 32'd0, 1'b0, 6'h3F, 5'd10);
      step();
      drive(1'b1, 4'd2, 48'h3, 48'h1, 32'd0, 1'b0, 6'h3F, 5'd11);
      step();
      e_base = emitted;
      drive(1'b1, 4'd3, 48'h4, 48'h2, 32'd0, 1'b0, 6'h3F, 5'd12);
      flush = 1'b1; out_ready = 1'b0;
      step();
      flush = 1'b0; out_ready = 1'b1;
      idle();
      chk("flush_out_valid", 64'(s_out_valid), 64'(0));
      for (int i = 0; i < 3; i++) begin
         step();
         chk("flush_quiet", 64'(s_out_valid), 64'(0));
      end
      chk("flush_emitted", 64'(emitted - e_base), 64'(0));
      one(4'd0, 48'h010203040506, 48'h010101010101, 32'd0, 1'b0, 6'h3F, 5'd13,
          48'h020304050607, 48'h020304050607);

      // asynchronous reset while stalled and full
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 4'd8, 48'({$urandom(), $urandom()}), 48'({$urandom(), $urandom()}), 32'd0, 1'b0,
               6'h3F, 5'(20 + i));
         step();
      end
      idle();
      rst = 1'b0;
      #1;
      chk("mid_rst_valid", 64'(s_out_valid), 64'(0));
      chk("mid_rst_result", 64'(s_result), 64'(0));
      chk("mid_rst_vd", 64'(s_vd_out), 64'(0));
      chk("mid_rst_ill", 64'(s_illegal), 64'(0));
      chk("mid_rst_wrap", 64'(w_out_valid), 64'(0));
      q.delete();
      @(posedge clk);
      #1 rst = 1'b1;
      #1 chk("post_rst_in_ready", 64'(s_in_ready), 64'(1));
      out_ready = 1'b1;

      for (int i = 0; i < 400; i++) begin
         flush = $urandom_range(0, 31) == 0;
         out_ready = $urandom_range(0, 9) < 7;
         drive($urandom_range(0, 9) < 7, 4'($urandom_range(0, 15)), 48'({$urandom(), $urandom()}),
               48'({$urandom(), $urandom()}), $urandom(), $urandom_range(0, 3) == 0,
               6'($urandom_range(0, 63)), 5'($urandom_range(0, 31)));
         step();
      end
      flush = 1'b0; out_ready = 1'b1;
      idle();
      repeat (4) step();
      chk("drain_empty", 64'(q.size()), 64'(0));
      chk("drain_valid", 64'(s_out_valid), 64'(0));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
